// File: rtl/zap_fetch_main.sv
// ----------------------------------------------------------------------------
// zap_fetch_main
//
// Fetch stage of the ZAP pipeline, directly upstream of predecode. It
// registers the word returned by instruction memory together with its PC,
// PC+8 (PC+4 in Thumb) and a prefetch-abort flag. It also owns the branch
// prediction table: an array of 2-bit saturating counters. Predecode reads an
// entry for every fetched instruction, and branch resolution in the ALU
// writes entries back.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_clear_from_writeback    flush (highest priority)
//   i_data_stall              hold
//   i_clear_from_alu          flush
//   i_stall_from_shifter      hold
//   i_stall_from_issue        hold
//   i_clear_from_decode       flush (predicted-taken branch)
//   i_stall_from_decode       hold (lowest priority)
//   i_pc_ff, i_cpu_mode       fetch address and CPSR (T bit selects Thumb)
//   i_instruction, i_valid    fetched word and its valid
//   i_instr_abort             prefetch abort on this fetch
//   i_bp_upd_*                predictor update from branch resolution
//   o_*                       registered outputs to predecode
// ----------------------------------------------------------------------------
module zap_fetch_main #(
    parameter int BP_ENTRIES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_clear_from_decode,
    input  logic        i_stall_from_decode,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_cpu_mode,
    input  logic [31:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_instr_abort,
    input  logic        i_bp_upd_valid,
    input  logic [31:0] i_bp_upd_pc,
    input  logic [1:0]  i_bp_upd_old,
    input  logic        i_bp_upd_taken,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken
);

    localparam int IDX_W = $clog2(BP_ENTRIES);
    localparam int T_BIT = 5;

    // Prediction states.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] ST  = 2'd3;

    // Pipeline register actions.
    localparam logic [1:0] ACT_LOAD  = 2'd0;
    localparam logic [1:0] ACT_HOLD  = 2'd1;
    localparam logic [1:0] ACT_CLEAR = 2'd2;

    logic [1:0]       r_bp_table [BP_ENTRIES];

    logic [31:0]      r_instruction;
    logic             r_valid;
    logic             r_instr_abort;
    logic [31:0]      r_pc_ff;
    logic [31:0]      r_pc_plus_8_ff;
    logic [1:0]       r_taken;

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_upd_new;
    logic [1:0]       w_rd_state;
    logic [1:0]       w_action;
    logic             w_unused;

    // Halfword granularity so adjacent Thumb branches get their own counters.
    assign w_rd_idx  = i_pc_ff[IDX_W:1];
    assign w_upd_idx = i_bp_upd_pc[IDX_W:1];

    // Bits that never reach the index or the mode decode.
    assign w_unused = ^{i_cpu_mode[31:T_BIT+1], i_cpu_mode[T_BIT-1:0],
                        i_bp_upd_pc[31:IDX_W+1], i_bp_upd_pc[0]};

    // Saturating increment/decrement of the state carried with the branch.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_upd_new = i_bp_upd_old;
        if (i_bp_upd_taken) begin
            if (i_bp_upd_old != ST)
                w_upd_new = i_bp_upd_old + 2'd1;
        end else begin
            if (i_bp_upd_old != SNT)
                w_upd_new = i_bp_upd_old - 2'd1;
        end
    end

    // Write-first: a same-cycle update to the entry being read wins.
    assign w_rd_state = (i_bp_upd_valid && (w_upd_idx == w_rd_idx)) ?
                        w_upd_new : r_bp_table[w_rd_idx];

    // Front-end stall/clear priority, highest first.
    always_comb begin
        w_action = ACT_LOAD;
        if (i_clear_from_writeback)    w_action = ACT_CLEAR;
        else if (i_data_stall)         w_action = ACT_HOLD;
        else if (i_clear_from_alu)     w_action = ACT_CLEAR;
        else if (i_stall_from_shifter) w_action = ACT_HOLD;
        else if (i_stall_from_issue)   w_action = ACT_HOLD;
        else if (i_clear_from_decode)  w_action = ACT_CLEAR;
        else if (i_stall_from_decode)  w_action = ACT_HOLD;
    end

    // Predictor table. Updates ignore stalls and flushes entirely.
    // NOTE: this array is reset entry by entry because a known WNT start
    // state is architecturally visible, so it maps to flops rather than RAM.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < BP_ENTRIES; i++)
                r_bp_table[i] <= WNT;
        end else if (i_bp_upd_valid) begin
            r_bp_table[w_upd_idx] <= w_upd_new;
        end
    end

    // Output pipeline register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instruction  <= 32'd0;
            r_valid        <= 1'b0;
            r_instr_abort  <= 1'b0;
            r_pc_ff        <= 32'd0;
            r_pc_plus_8_ff <= 32'd8;
            r_taken        <= SNT;
        end else begin
            case (w_action)
                ACT_CLEAR: begin
                    r_instruction  <= 32'd0;
                    r_valid        <= 1'b0;
                    r_instr_abort  <= 1'b0;
                    r_pc_ff        <= 32'd0;
                    r_pc_plus_8_ff <= 32'd8;
                    r_taken        <= SNT;
                end
                ACT_LOAD: begin
                    r_instruction  <= i_valid ? i_instruction : 32'd0;
                    r_valid        <= i_valid;
                    r_instr_abort  <= i_instr_abort & i_valid;
                    r_pc_ff        <= i_pc_ff;
                    r_pc_plus_8_ff <= i_pc_ff + (i_cpu_mode[T_BIT] ? 32'd4 : 32'd8);
                    r_taken        <= w_rd_state;
                end
                default: ; // hold: everything, including o_taken, keeps its value
            endcase
        end
    end

    assign o_instruction  = r_instruction;
    assign o_valid        = r_valid;
    assign o_instr_abort  = r_instr_abort;
    assign o_pc_ff        = r_pc_ff;
    assign o_pc_plus_8_ff = r_pc_plus_8_ff;
    assign o_taken        = r_taken;

endmodule

// File: tb/tb_zap_fetch_main.sv
// ----------------------------------------------------------------------------
// tb_zap_fetch_main
//
// Directed bench for zap_fetch_main. A reference model holds the predictor
// table as an int array and derives the next outputs from the current
// inputs at each clock edge; a compare process checks every output against
// it on each falling edge. Literal expectations after each directed step
// pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_zap_fetch_main;

    localparam int BP = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_wb, data_stall, clr_alu, stall_sh, stall_iss, clr_dec, stall_dec;
    logic [31:0] pc, cpu_mode, instr;
    logic        valid, abort;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc;
    logic [1:0]  upd_old;

    logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic        o_valid, o_instr_abort;
    logic [1:0]  o_taken;

    int checks   = 0;
    int failures = 0;

    zap_fetch_main #(.BP_ENTRIES(BP)) dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_clear_from_writeback (clr_wb),
        .i_data_stall           (data_stall),
        .i_clear_from_alu       (clr_alu),
        .i_stall_from_shifter   (stall_sh),
        .i_stall_from_issue     (stall_iss),
        .i_clear_from_decode    (clr_dec),
        .i_stall_from_decode    (stall_dec),
        .i_pc_ff                (pc),
        .i_cpu_mode             (cpu_mode),
        .i_instruction          (instr),
        .i_valid                (valid),
        .i_instr_abort          (abort),
        .i_bp_upd_valid         (upd_valid),
        .i_bp_upd_pc            (upd_pc),
        .i_bp_upd_old           (upd_old),
        .i_bp_upd_taken         (upd_taken),
        .o_instruction          (o_instruction),
        .o_valid                (o_valid),
        .o_instr_abort          (o_instr_abort),
        .o_pc_ff                (o_pc_ff),
        .o_pc_plus_8_ff         (o_pc_plus_8_ff),
        .o_taken                (o_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_table [BP];
    logic [31:0] e_instr = 32'd0, e_pc = 32'd0, e_pc8 = 32'd8;
    logic        e_valid = 1'b0, e_abort = 1'b0;
    int          e_taken = 0;
    bit          ctl [7];
    bit          is_clear [7] = '{1, 0, 1, 0, 0, 1, 0};
    bit          found;
    int          act;  // 0 load, 1 hold, 2 clear

    function automatic int idx(input logic [31:0] a);
        return int'((a / 2) % BP);
    endfunction

    function automatic int sat(input int old, input bit taken);
        int v;
        v = taken ? old + 1 : old - 1;
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BP; i++) m_table[i] = 1;
            e_instr = 32'd0; e_valid = 1'b0; e_abort = 1'b0;
            e_pc = 32'd0; e_pc8 = 32'd8; e_taken = 0;
        end else begin
            // Applying the update before the read gives write-first behaviour.
            if (upd_valid) m_table[idx(upd_pc)] = sat(int'(upd_old), upd_taken);
            ctl = '{clr_wb, data_stall, clr_alu, stall_sh, stall_iss, clr_dec, stall_dec};
            act = 0;
            found = 1'b0;
            for (int k = 0; k < 7; k++) begin
                if (!found && ctl[k]) begin
                    found = 1'b1;
                    act = is_clear[k] ? 2 : 1;
                end
            end
            if (act == 2) begin
                e_instr = 32'd0; e_valid = 1'b0; e_abort = 1'b0;
                e_pc = 32'd0; e_pc8 = 32'd8; e_taken = 0;
            end else if (act == 0) begin
                e_valid = valid;
                e_abort = valid && abort;
                e_instr = valid ? instr : 32'd0;
                e_pc    = pc;
                e_pc8   = pc + (cpu_mode[5] ? 32'd4 : 32'd8);
                e_taken = m_table[idx(pc)];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc_instruction", o_instruction,  e_instr);
        check("cyc_valid",       {31'd0, o_valid},       {31'd0, e_valid});
        check("cyc_abort",       {31'd0, o_instr_abort}, {31'd0, e_abort});
        check("cyc_pc",          o_pc_ff,        e_pc);
        check("cyc_pc8",         o_pc_plus_8_ff, e_pc8);
        check("cyc_taken",       {30'd0, o_taken}, e_taken[31:0]);
    end

    // ---------------- stimulus ----------------
    task automatic idle;
        clr_wb = 0; data_stall = 0; clr_alu = 0; stall_sh = 0;
        stall_iss = 0; clr_dec = 0; stall_dec = 0;
        pc = 32'd0; cpu_mode = 32'd0; instr = 32'd0; valid = 0; abort = 0;
        upd_valid = 0; upd_pc = 32'd0; upd_old = 2'd0; upd_taken = 0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w);
        idle();
        pc = a; instr = w; valid = 1;
    endtask

    task automatic update(input logic [31:0] a, input logic [1:0] old, input bit tk);
        upd_valid = 1; upd_pc = a; upd_old = old; upd_taken = tk;
    endtask

    initial begin
        idle();
        step(); step();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_pc8",   o_pc_plus_8_ff,   32'd8);
        check("rst_taken", {30'd0, o_taken}, 32'd0);
        rst = 1'b0;

        // Basic ARM load.
        fetch(32'h100, 32'hE1A00000); step();
        check("arm_valid", {31'd0, o_valid}, 32'd1);
        check("arm_instr", o_instruction,    32'hE1A00000);
        check("arm_pc",    o_pc_ff,          32'h100);
        check("arm_pc8",   o_pc_plus_8_ff,   32'h108);
        check("arm_taken", {30'd0, o_taken}, 32'd1);

        // Thumb PC+4 and ARM wrap-around.
        fetch(32'h202, 32'h0000B500); cpu_mode = 32'h20; step();
        check("thumb_pc8", o_pc_plus_8_ff, 32'h206);
        fetch(32'hFFFFFFFC, 32'hEAFFFFFE); step();
        check("wrap_pc8", o_pc_plus_8_ff, 32'h4);

        // Counter walk at 0x40, read back with separate fetches.
        fetch(32'h0, 32'h1); update(32'h40, 2'd1, 1); step();
        fetch(32'h40, 32'h2); step();
        check("bp_after_1", {30'd0, o_taken}, 32'd2);
        fetch(32'h0, 32'h1); update(32'h40, 2'd2, 1); step();
        fetch(32'h40, 32'h2); step();
        check("bp_after_2", {30'd0, o_taken}, 32'd3);
        fetch(32'h0, 32'h1); update(32'h40, 2'd3, 1); step();
        fetch(32'h40, 32'h2); step();
        check("bp_sat_hi", {30'd0, o_taken}, 32'd3);
        fetch(32'h0, 32'h1); update(32'h40, 2'd0, 0); step();
        fetch(32'h40, 32'h2); step();
        check("bp_sat_lo", {30'd0, o_taken}, 32'd0);
        // Neighbouring halfword must not alias 0x40.
        fetch(32'h42, 32'h3); step();
        check("bp_halfword", {30'd0, o_taken}, 32'd1);

        // Stall/clear priority.
        fetch(32'h300, 32'h11111111); step();
        fetch(32'h304, 32'h22222222); stall_iss = 1; clr_dec = 1; step();
        check("hold_iss_pc",    o_pc_ff,          32'h300);
        check("hold_iss_valid", {31'd0, o_valid}, 32'd1);
        fetch(32'h304, 32'h22222222); clr_dec = 1; step();
        check("clr_dec_valid", {31'd0, o_valid}, 32'd0);
        check("clr_dec_instr", o_instruction,    32'd0);
        fetch(32'h308, 32'h33333333); step();
        fetch(32'h30C, 32'h44444444); data_stall = 1; clr_alu = 1; step();
        check("hold_data_pc",    o_pc_ff,       32'h308);
        check("hold_data_instr", o_instruction, 32'h33333333);
        fetch(32'h310, 32'h55555555); stall_dec = 1; step();
        check("hold_dec_pc", o_pc_ff, 32'h308);

        // Read/write collision forwards the new value.
        fetch(32'h80, 32'h66666666); update(32'h80, 2'd1, 1); step();
        check("fwd_taken", {30'd0, o_taken}, 32'd2);
        fetch(32'h80, 32'h66666666); step();
        check("fwd_stored", {30'd0, o_taken}, 32'd2);

        // Abort qualified by valid.
        fetch(32'h400, 32'h77777777); abort = 1; step();
        check("abort_set", {31'd0, o_instr_abort}, 32'd1);
        fetch(32'h404, 32'h88888888); abort = 1; valid = 0; step();
        check("abort_invalid", {31'd0, o_instr_abort}, 32'd0);
        check("invalid_instr", o_instruction,          32'd0);

        // Flush and update together both take effect.
        fetch(32'h500, 32'h99999999); clr_wb = 1; update(32'h40, 2'd1, 1); step();
        check("flush_wb_valid", {31'd0, o_valid}, 32'd0);
        fetch(32'h40, 32'hAAAAAAAA); step();
        check("flush_upd_taken", {30'd0, o_taken}, 32'd2);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_instr", o_instruction,    32'd0);
        check("arst_pc",    o_pc_ff,          32'd0);
        check("arst_pc8",   o_pc_plus_8_ff,   32'd8);
        check("arst_taken", {30'd0, o_taken}, 32'd0);
        rst = 1'b0;
        fetch(32'h40, 32'hBBBBBBBB); step();
        check("arst_table", {30'd0, o_taken}, 32'd1);
        idle(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
